// File: rtl/ber_meas_ctrl_if.sv
// Result port bundle for the BER measurement sequencer.
// The master drives the result fields and valid; the slave returns ready.
interface ber_meas_ctrl_if #(
    parameter int CNT_W = 64
);
    logic             o_res_valid;
    logic             i_res_ready;
    logic [CNT_W-1:0] o_res_bits_I;
    logic [CNT_W-1:0] o_res_bits_Q;
    logic [CNT_W-1:0] o_res_err_I;
    logic [CNT_W-1:0] o_res_err_Q;
    logic [1:0]       o_res_rot;
    logic [1:0]       o_res_status;

    modport master (
        output o_res_valid,
        input  i_res_ready,
        output o_res_bits_I,
        output o_res_bits_Q,
        output o_res_err_I,
        output o_res_err_Q,
        output o_res_rot,
        output o_res_status
    );

    modport slave (
        input  o_res_valid,
        output i_res_ready,
        input  o_res_bits_I,
        input  o_res_bits_Q,
        input  o_res_err_I,
        input  o_res_err_Q,
        input  o_res_rot,
        input  o_res_status
    );
endinterface

// File: rtl/ber_meas_ctrl.sv
// BER measurement sequencer: clear, sync wait, windowed count, report.
// Optional macro BER_MEAS_CTRL_AUTORESTART_EN repeats measurements after each report.
module ber_meas_ctrl #(
    parameter int CNT_W = 64,
    parameter int WIN_W = 32,
    parameter int TMO_W = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic [TMO_W-1:0] i_sync_tmo,
    input  logic             i_sync_lock,
    input  logic [1:0]       i_rot_ang,
    input  logic [CNT_W-1:0] i_cnt_ber_I,
    input  logic [CNT_W-1:0] i_cnt_ber_Q,
    input  logic [CNT_W-1:0] i_cnt_err_I,
    input  logic [CNT_W-1:0] i_cnt_err_Q,
    output logic             o_ber_clr,
    output logic [32:0]      o_count_sym,
    output logic             o_busy,
    output logic [2:0]       o_state,
    ber_meas_ctrl_if.master  res
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_SYNC    = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_REPORT  = 3'd4;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_TMO   = 2'b01;
    localparam logic [1:0] ST_ABORT = 2'b10;
    localparam logic [1:0] ST_ROT   = 2'b11;

    logic [2:0]       state;
    logic [2:0]       nxt;
    logic [WIN_W-1:0] win_len_q;
    logic [TMO_W-1:0] tmo_q;
    logic [WIN_W-1:0] win_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [WIN_W-1:0] win_eff;
    logic [WIN_W-1:0] win_nx;
    logic [TMO_W-1:0] tmo_sat;
    logic [TMO_W-1:0] tmo_nx;
    logic             tmo_hit;
    logic             win_hit;
    logic             rot_diff;
    logic             go_clr;
    logic             go_rep;
    logic             go_meas;
    logic             meas_done;
    logic [1:0]       rep_st;
    logic [CNT_W-1:0] base_bi;
    logic [CNT_W-1:0] base_bq;
    logic [CNT_W-1:0] base_ei;
    logic [CNT_W-1:0] base_eq;
    logic [1:0]       rot_base;
    logic             rot_chg;

    assign o_state = state;

    // Next-state decode plus the saturating window/timeout increments
    always_comb begin
        // A programmed window of 0 behaves as a single-symbol window
        win_eff   = (win_len_q == '0) ? WIN_W'(1) : win_len_q;
        // With no timeout programmed the counter just saturates at all-ones
        tmo_sat   = (tmo_q == '0) ? '1 : tmo_q;
        win_nx    = win_cnt;
        tmo_nx    = tmo_cnt;
        if (i_valid && win_cnt != win_eff) win_nx = win_cnt + WIN_W'(1);
        if (i_valid && tmo_cnt != tmo_sat) tmo_nx = tmo_cnt + TMO_W'(1);
        tmo_hit   = (tmo_q != '0) && (tmo_nx == tmo_q);
        win_hit   = (win_nx == win_eff);
        rot_diff  = (i_rot_ang != rot_base);
        nxt       = state;
        go_clr    = 1'b0;
        go_rep    = 1'b0;
        go_meas   = 1'b0;
        meas_done = 1'b0;
        rep_st    = ST_OK;
        unique case (state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    nxt    = S_CLEAR;
                    go_clr = 1'b1;
                end
            end
            S_CLEAR: begin
                if (i_abort) begin
                    nxt    = S_REPORT;
                    go_rep = 1'b1;
                    rep_st = ST_ABORT;
                end else begin
                    nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                if (i_abort) begin
                    nxt    = S_REPORT;
                    go_rep = 1'b1;
                    rep_st = ST_ABORT;
                end else if (i_sync_lock) begin
                    nxt     = S_MEASURE;
                    go_meas = 1'b1;
                end else if (tmo_hit) begin
                    nxt    = S_REPORT;
                    go_rep = 1'b1;
                    rep_st = ST_TMO;
                end
            end
            S_MEASURE: begin
                if (i_abort) begin
                    nxt    = S_REPORT;
                    go_rep = 1'b1;
                    rep_st = ST_ABORT;
                end else if (win_hit) begin
                    nxt       = S_REPORT;
                    go_rep    = 1'b1;
                    meas_done = 1'b1;
                    rep_st    = (rot_chg || rot_diff) ? ST_ROT : ST_OK;
                end
            end
            S_REPORT: begin
                if (res.i_res_ready) begin
`ifdef BER_MEAS_CTRL_AUTORESTART_EN
                    // An aborted report breaks the continuous loop
                    if (res.o_res_status == ST_ABORT) begin
                        nxt = S_IDLE;
                    end else begin
                        nxt    = S_CLEAR;
                        go_clr = 1'b1;
                    end
`else
                    nxt = S_IDLE;
`endif
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // FSM state, busy flag and the one-cycle datapath clear
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= S_IDLE;
            o_busy    <= 1'b0;
            o_ber_clr <= 1'b0;
        end else begin
            state     <= nxt;
            o_busy    <= (nxt != S_IDLE);
            o_ber_clr <= go_clr;
        end
    end

    // Latched configuration and symbol/window/timeout counters
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            win_len_q   <= '0;
            tmo_q       <= '0;
            win_cnt     <= '0;
            tmo_cnt     <= '0;
            o_count_sym <= '0;
        end else if (go_clr) begin
            if (state == S_IDLE) begin
                win_len_q <= i_win_len;
                tmo_q     <= i_sync_tmo;
            end
            win_cnt     <= '0;
            tmo_cnt     <= '0;
            o_count_sym <= '0;
        end else if (state == S_SYNC || state == S_MEASURE) begin
            if (i_valid) o_count_sym <= o_count_sym + 33'd1;
            if (state == S_SYNC) tmo_cnt <= tmo_nx;
            else                 win_cnt <= win_nx;
        end
    end

    // Baselines taken at lock, and sticky rotation-change tracking
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            base_bi  <= '0;
            base_bq  <= '0;
            base_ei  <= '0;
            base_eq  <= '0;
            rot_base <= '0;
            rot_chg  <= 1'b0;
        end else if (go_meas) begin
            base_bi  <= i_cnt_ber_I;
            base_bq  <= i_cnt_ber_Q;
            base_ei  <= i_cnt_err_I;
            base_eq  <= i_cnt_err_Q;
            rot_base <= i_rot_ang;
            rot_chg  <= 1'b0;
        end else if (state == S_MEASURE && rot_diff) begin
            rot_chg <= 1'b1;
        end
    end

    // Result capture on REPORT entry, held until the consumer accepts
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            res.o_res_valid  <= 1'b0;
            res.o_res_bits_I <= '0;
            res.o_res_bits_Q <= '0;
            res.o_res_err_I  <= '0;
            res.o_res_err_Q  <= '0;
            res.o_res_rot    <= '0;
            res.o_res_status <= '0;
        end else if (go_rep) begin
            res.o_res_valid  <= 1'b1;
            res.o_res_status <= rep_st;
            if (meas_done) begin
                res.o_res_bits_I <= i_cnt_ber_I - base_bi;
                res.o_res_bits_Q <= i_cnt_ber_Q - base_bq;
                res.o_res_err_I  <= i_cnt_err_I - base_ei;
                res.o_res_err_Q  <= i_cnt_err_Q - base_eq;
                res.o_res_rot    <= i_rot_ang;
            end else begin
                res.o_res_bits_I <= '0;
                res.o_res_bits_Q <= '0;
                res.o_res_err_I  <= '0;
                res.o_res_err_Q  <= '0;
                res.o_res_rot    <= '0;
            end
        end else if (state == S_REPORT && res.i_res_ready) begin
            res.o_res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ber_meas_ctrl.sv
// Directed bench for ber_meas_ctrl.
// Expected values are hand-derived from the sequencer behaviour.
module tb_ber_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, start, abort, lock;
    logic [31:0] win_len, sync_tmo;
    logic [1:0]  rot;
    logic [63:0] ber_i, ber_q, err_i, err_q;
    logic        ber_clr, busy;
    logic [32:0] count_sym;
    logic [2:0]  state;

    int errs   = 0;
    int checks = 0;

`ifdef BER_MEAS_CTRL_AUTORESTART_EN
    localparam logic [2:0] AFTER_OK = 3'd1;
`else
    localparam logic [2:0] AFTER_OK = 3'd0;
`endif

    ber_meas_ctrl_if #(.CNT_W(64)) res_if ();

    ber_meas_ctrl #(.CNT_W(64), .WIN_W(32), .TMO_W(32)) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_valid     (valid),
        .i_start     (start),
        .i_abort     (abort),
        .i_win_len   (win_len),
        .i_sync_tmo  (sync_tmo),
        .i_sync_lock (lock),
        .i_rot_ang   (rot),
        .i_cnt_ber_I (ber_i),
        .i_cnt_ber_Q (ber_q),
        .i_cnt_err_I (err_i),
        .i_cnt_err_Q (err_q),
        .o_ber_clr   (ber_clr),
        .o_count_sym (count_sym),
        .o_busy      (busy),
        .o_state     (state),
        .res         (res_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start, pass CLEAR, land in SYNC
    task automatic launch(input logic [31:0] w, input logic [31:0] t);
        win_len  = w;
        sync_tmo = t;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    // in auto-restart mode, abort the fresh CLEAR and accept the abort report
    task automatic exit_loop();
`ifdef BER_MEAS_CTRL_AUTORESTART_EN
        res_if.i_res_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        res_if.i_res_ready = 1'b1;
        tick();
        res_if.i_res_ready = 1'b0;
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        {valid, start, abort, lock} = '0;
        win_len = '0;
        sync_tmo = '0;
        rot = '0;
        {ber_i, ber_q, err_i, err_q} = '0;
        res_if.i_res_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_valid", 64'(res_if.o_res_valid), 64'd0);
        chk("rst_clr", 64'(ber_clr), 64'd0);
        chk("rst_sym", 64'(count_sym), 64'd0);
        rst_n = 1'b1;
        tick();

        // normal window: 37 sync symbols, 100-symbol window
        win_len  = 32'd100;
        sync_tmo = 32'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("a_clear_state", 64'(state), 64'd1);
        chk("a_clr_pulse", 64'(ber_clr), 64'd1);
        chk("a_busy", 64'(busy), 64'd1);
        tick();
        chk("a_sync_state", 64'(state), 64'd2);
        chk("a_clr_low", 64'(ber_clr), 64'd0);
        valid = 1'b1;
        for (int i = 0; i < 37; i++) tick();
        valid = 1'b0;
        ber_i = 64'd1000;
        ber_q = 64'd2000;
        err_i = 64'd10;
        err_q = 64'd20;
        lock  = 1'b1;
        tick();
        lock = 1'b0;
        chk("a_meas_state", 64'(state), 64'd3);
        chk("a_sym_lock", 64'(count_sym), 64'd37);
        ber_i = 64'd1100;
        ber_q = 64'd2100;
        err_i = 64'd15;
        err_q = 64'd23;
        valid = 1'b1;
        for (int i = 0; i < 99; i++) tick();
        chk("a_not_yet", 64'(state), 64'd3);
        tick();
        valid = 1'b0;
        chk("a_rep_state", 64'(state), 64'd4);
        chk("a_valid", 64'(res_if.o_res_valid), 64'd1);
        chk("a_status", 64'(res_if.o_res_status), 64'd0);
        chk("a_err_i", res_if.o_res_err_I, 64'd5);
        chk("a_err_q", res_if.o_res_err_Q, 64'd3);
        chk("a_bits_i", res_if.o_res_bits_I, 64'd100);
        chk("a_bits_q", res_if.o_res_bits_Q, 64'd100);
        chk("a_sym", 64'(count_sym), 64'd137);
        res_if.i_res_ready = 1'b1;
        tick();
        res_if.i_res_ready = 1'b0;
        chk("a_after", 64'(state), 64'(AFTER_OK));
        chk("a_valid_off", 64'(res_if.o_res_valid), 64'd0);
        exit_loop();

        // sync timeout after 50 symbols, ready already high on entry
        launch(32'd10, 32'd50);
        valid = 1'b1;
        for (int i = 0; i < 49; i++) tick();
        chk("b_still_sync", 64'(state), 64'd2);
        res_if.i_res_ready = 1'b1;
        tick();
        valid = 1'b0;
        chk("b_rep_state", 64'(state), 64'd4);
        chk("b_valid", 64'(res_if.o_res_valid), 64'd1);
        chk("b_status", 64'(res_if.o_res_status), 64'd1);
        chk("b_err_i", res_if.o_res_err_I, 64'd0);
        chk("b_bits_i", res_if.o_res_bits_I, 64'd0);
        tick();
        res_if.i_res_ready = 1'b0;
        chk("b_valid_1cyc", 64'(res_if.o_res_valid), 64'd0);
        chk("b_after", 64'(state), 64'(AFTER_OK));
        exit_loop();

        // abort on 10th window symbol
        launch(32'd20, 32'd0);
        lock = 1'b1;
        tick();
        lock  = 1'b0;
        err_i = 64'd99;
        valid = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        valid = 1'b0;
        chk("c_rep_state", 64'(state), 64'd4);
        chk("c_status", 64'(res_if.o_res_status), 64'd2);
        chk("c_err_i", res_if.o_res_err_I, 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("c_abort_in_rep", 64'(state), 64'd4);
        res_if.i_res_ready = 1'b1;
        tick();
        res_if.i_res_ready = 1'b0;
        chk("c_idle", 64'(state), 64'd0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("c_start_abort", 64'(state), 64'd0);
        chk("c_sa_busy", 64'(busy), 64'd0);

        // window length 0 acts as 1
        launch(32'd0, 32'd0);
        lock = 1'b1;
        tick();
        lock  = 1'b0;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("w0_rep", 64'(state), 64'd4);
        res_if.i_res_ready = 1'b1;
        tick();
        res_if.i_res_ready = 1'b0;
        exit_loop();

        // rotation glitch mid-window and error counter wrap
        err_i = 64'hFFFF_FFFF_FFFF_FFFE;
        ber_i = 64'd500;
        rot   = 2'b00;
        launch(32'd10, 32'd0);
        lock = 1'b1;
        tick();
        lock  = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rot = (i >= 3 && i < 6) ? 2'b01 : 2'b00;
            if (i == 9) err_i = 64'd3;
            tick();
        end
        valid = 1'b0;
        chk("d_rep_state", 64'(state), 64'd4);
        chk("d_status", 64'(res_if.o_res_status), 64'd3);
        chk("d_rot", 64'(res_if.o_res_rot), 64'd0);
        chk("d_err_i_wrap", res_if.o_res_err_I, 64'd5);
        chk("d_bits_i", res_if.o_res_bits_I, 64'd0);
        err_i = 64'd77;
        rot   = 2'b10;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("d_hold_valid", 64'(res_if.o_res_valid), 64'd1);
            chk("d_hold_err", res_if.o_res_err_I, 64'd5);
            chk("d_hold_st", 64'(res_if.o_res_status), 64'd3);
        end
        rot = 2'b00;
        res_if.i_res_ready = 1'b1;
        tick();
        res_if.i_res_ready = 1'b0;
        chk("d_after", 64'(state), 64'(AFTER_OK));
        chk("d_clr_after", 64'(ber_clr), 64'(AFTER_OK == 3'd1));
        exit_loop();

        // asynchronous reset mid-MEASURE
        launch(32'd100, 32'd0);
        lock = 1'b1;
        tick();
        lock  = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("e_meas", 64'(state), 64'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("e_busy", 64'(busy), 64'd0);
        chk("e_state", 64'(state), 64'd0);
        chk("e_valid", 64'(res_if.o_res_valid), 64'd0);
        chk("e_clr", 64'(ber_clr), 64'd0);
        chk("e_sym", 64'(count_sym), 64'd0);
        tick();
        tick();
        valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("e_idle", 64'(state), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ber_meas_ctrl.md
Name: ber_meas_ctrl

Overview:
Measurement sequencer for the I/Q BER counter datapath. On a start command it:
- clears the BER block and drives its symbol counter;
- waits for PRBS sync lock, with a timeout;
- measures errors over a programmed window of symbols;
- returns per-lane bit and error deltas, plus the detected rotation, through a valid/ready result port.

It sits between the host/register side and the BER counter instance.

Parameters:
- CNT_W, 64, width of BER/error counters from the datapath and of result fields.
- WIN_W, 32, width of measurement-window length.
- TMO_W, 32, width of sync-timeout length.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  symbol strobe; one symbol per high cycle.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_abort  in  1  abort pulse.
- i_win_len  in  WIN_W  window length in symbols; latched at start.
- i_sync_tmo  in  TMO_W  sync timeout in symbols; latched at start; 0 = no timeout.
- i_sync_lock  in  1  datapath PRBS sync achieved.
- i_rot_ang  in  2  detected constellation rotation from datapath.
- i_cnt_ber_I, i_cnt_ber_Q  in  CNT_W  datapath compared-bit counters.
- i_cnt_err_I, i_cnt_err_Q  in  CNT_W  datapath error counters.
- o_ber_clr  out  1  one-cycle clear pulse to the BER datapath.
- o_count_sym  out  33  symbol count driven to the datapath.
- o_busy  out  1  high in any state except IDLE.
- o_state  out  3  encoded FSM state: IDLE=0, CLEAR=1, SYNC=2, MEASURE=3, REPORT=4.
- o_res_valid  out  1  result available.
- i_res_ready  in  1  result consumer ready.
- o_res_bits_I, o_res_bits_Q, o_res_err_I, o_res_err_Q  out  CNT_W  window deltas.
- o_res_rot  out  2  rotation at window end.
- o_res_status  out  2  00 ok, 01 sync timeout, 10 aborted, 11 rotation changed in window.

Behaviour:
Reset:
- Reset values: all outputs 0, FSM in IDLE.
- All outputs are registered.
- Asserting reset mid-operation returns to IDLE immediately and drops o_res_valid without a handshake.

FSM, one transition per clock:
- IDLE:
  - i_start and not i_abort -> CLEAR; latch i_win_len and i_sync_tmo.
  - If i_start and i_abort are high together, stay in IDLE.
- CLEAR (exactly 1 cycle):
  - o_ber_clr = 1, o_count_sym <= 0, window/timeout counters <= 0; then -> SYNC.
  - o_ber_clr rises on the cycle after i_start is sampled.
- SYNC:
  - Each i_valid increments o_count_sym and the timeout counter.
  - i_sync_lock = 1 -> MEASURE. On that transition, snapshot the four datapath counters as baselines and snapshot i_rot_ang.
  - Otherwise, if latched timeout != 0 and timeout count reaches it -> REPORT with status 01 and all delta fields 0.
  - Lock and timeout in the same cycle: lock wins.
- MEASURE:
  - Each i_valid increments o_count_sym and the window counter.
  - When the window counter equals the latched length -> REPORT. A latched length of 0 is treated as 1.
  - On that transition, deltas = current counter - baseline, modulo 2^CNT_W (wrap is tolerated).
  - o_res_rot = i_rot_ang at that cycle.
  - Status = 11 if i_rot_ang ever differed from its snapshot during MEASURE, else 00.
  - Loss of i_sync_lock inside MEASURE is ignored.
- REPORT:
  - o_res_valid = 1 and result fields held stable until i_res_ready is sampled high; then -> IDLE and o_res_valid <= 0 on the same edge.
  - i_res_ready already high on REPORT entry: valid is high for exactly 1 cycle.
  - o_count_sym holds its value.

Abort and start rules:
- i_abort in CLEAR, SYNC or MEASURE -> REPORT next cycle with status 10 and zero deltas.
- i_abort in REPORT or IDLE is ignored.
- i_start outside IDLE is ignored.

Counters:
- o_count_sym wraps at 2^33.
- Window and timeout counters are WIN_W and TMO_W wide and stop counting once they reach the terminal value.

Optional Feature:
BER_MEAS_CTRL_AUTORESTART_EN
- Defined: after the REPORT handshake the FSM goes to CLEAR instead of IDLE, using the same latched config; measurement repeats continuously.
  - An i_abort while in SYNC or MEASURE, or a REPORT with status 10, ends the loop: after that report is accepted the FSM goes to IDLE.
- Undefined: REPORT always returns to IDLE. The abort-ends-loop logic is not present.

Test Plan:
- Reset low for 2 cycles mid-MEASURE -> o_busy=0, o_state=0, o_res_valid=0, o_ber_clr=0 on the next edge.
- Start with win_len=100, sync_tmo=0; lock after 37 valid symbols; error counters advance by 5 (I) and 3 (Q) in window; bit counters by 100 each -> status 00, err_I=5, err_Q=3, bits=100/100, o_count_sym=137 in REPORT.
- Start with sync_tmo=50, lock never asserted -> REPORT after 50 valid symbols, status 01, deltas 0.
- Abort on the 10th window symbol -> REPORT next cycle, status 10, deltas 0. Start+abort in the same IDLE cycle -> stays IDLE.
- rot_ang 00 at lock, 01 for 3 symbols mid-window, back to 00 -> status 11, o_res_rot=00. Baseline err_I=2^64-2, final err_I=3 -> err_I delta 5.
- i_res_ready held low for 20 cycles -> valid and fields stable for 20 cycles; with AUTORESTART_EN, the handshake is followed by an o_ber_clr pulse on the next cycle.
